scroll_sched: RTL and testbench

Two-requester scheduler for the 3-digit scrolling display. It arbitrates between two message sources, each offering a 3-digit packed code. It loads the granted message into the display scroller as a 3-cycle digit-serial burst with a read strobe. It then generates the scroll-step tick and holds the display for a fixed number of full scroll passes before accepting the next message.

---
 rtl/scroll_sched_if.sv | 28 ++
 rtl/scroll_sched.sv | 161 ++++++++++++++++
 tb/tb_scroll_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scroll_sched_if.sv
// scroll_sched requester/scroller bundle.
// master drives requests, slave is the scheduler.
interface scroll_sched_if;
  logic        req0;
  logic [11:0] msg0;
  logic        ack0;
  logic        req1;
  logic [11:0] msg1;
  logic        ack1;
  logic        ld_rd;
  logic [3:0]  ld_dec;
  logic        tick;
  logic [2:0]  step;
  logic        busy;
  logic        grant;

  modport master (
    output req0, msg0, req1, msg1,
    input  ack0, ack1, ld_rd, ld_dec,
    input  tick, step, busy, grant
  );

  modport slave (
    input  req0, msg0, req1, msg1,
    output ack0, ack1, ld_rd, ld_dec,
    output tick, step, busy, grant
  );
endinterface

// File: rtl/scroll_sched.sv
// Two-requester scheduler for the 3-digit scroll display.
// SCROLL_SCHED_RR_EN selects round-robin, else fixed priority.
module scroll_sched #(
  parameter int TICK_DIV    = 50,
  parameter int HOLD_PASSES = 1
) (
  input  logic          clk,
  input  logic          rst,
  scroll_sched_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int QW = $clog2(HOLD_PASSES + 1);
  localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
  localparam logic [QW-1:0] QLAST = QW'(HOLD_PASSES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOAD,
    SHOW
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic [11:0]   msg_q, msg_d;
  logic [1:0]    lcnt_q, lcnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    step_q, step_d;
  logic [QW-1:0] pass_q, pass_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          ld_rd_q, ld_rd_d;
  logic [3:0]    ld_dec_q, ld_dec_d;
  logic          tick_q, tick_d;
  logic          busy_q, busy_d;
  logic          win;

  // pick the winner among the current requests
  always_comb begin
`ifdef SCROLL_SCHED_RR_EN
    if (bus.req0 && bus.req1) win = ~grant_q;
    else                      win = bus.req1;
`else
    win = bus.req1 & ~bus.req0;
`endif
  end

  // next state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    msg_d   = msg_q;
    lcnt_d  = lcnt_q;
    pre_d   = pre_q;
    step_d  = step_q;
    pass_d  = pass_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = GRANT;
          grant_d = win;
          msg_d   = win ? bus.msg1 : bus.msg0;
          ack0_d  = ~win;
          ack1_d  = win;
        end
      end
      GRANT: begin
        state_d = LOAD;
        lcnt_d  = '0;
        pre_d   = '0;
        step_d  = '0;
        pass_d  = '0;
      end
      LOAD: begin
        if (lcnt_q == 2'd2) begin
          state_d = SHOW;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + 2'd1;
        end
      end
      SHOW: begin
        if (pre_q == PMAX) begin
          pre_d = '0;
          if (step_q == 3'd6) begin
            step_d = '0;
            if (pass_q == QLAST) begin
              state_d = IDLE;
              pass_d  = '0;
            end else begin
              pass_d = pass_q + QW'(1);
            end
          end else begin
            step_d = step_q + 3'd1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    ld_rd_d  = (state_d == LOAD);
    tick_d   = (state_d == SHOW) && (pre_d == PMAX);
    ld_dec_d = 4'hF;
    if (state_d == LOAD) begin
      case (lcnt_d)
        2'd0:    ld_dec_d = msg_q[11:8];
        2'd1:    ld_dec_d = msg_q[7:4];
        default: ld_dec_d = msg_q[3:0];
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      msg_q    <= 12'hFFF;
      lcnt_q   <= '0;
      pre_q    <= '0;
      step_q   <= '0;
      pass_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      ld_rd_q  <= 1'b0;
      ld_dec_q <= 4'hF;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      msg_q    <= msg_d;
      lcnt_q   <= lcnt_d;
      pre_q    <= pre_d;
      step_q   <= step_d;
      pass_q   <= pass_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      ld_rd_q  <= ld_rd_d;
      ld_dec_q <= ld_dec_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.ld_rd  = ld_rd_q;
  assign bus.ld_dec = ld_dec_q;
  assign bus.tick   = tick_q;
  assign bus.step   = step_q;
  assign bus.busy   = busy_q;
  assign bus.grant  = grant_q;

endmodule

// File: tb/tb_scroll_sched.sv
// Bench for scroll_sched: timeline model plus
// directed scenarios and randomized requesters.
module tb_scroll_sched;

  localparam int TDA = 4;
  localparam int HPA = 1;
  localparam int TDB = 2;
  localparam int HPB = 3;
`ifdef SCROLL_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic       ack0;
    logic       ack1;
    logic       ld_rd;
    logic [3:0] ld_dec;
    logic       tick;
    logic [2:0] step;
    logic       busy;
    logic       grant;
  } out_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  scroll_sched_if ifa ();
  scroll_sched_if ifb ();

  scroll_sched #(.TICK_DIV(TDA), .HOLD_PASSES(HPA)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  scroll_sched #(.TICK_DIV(TDB), .HOLD_PASSES(HPB)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int td(input int i);
    return (i != 0) ? TDB : TDA;
  endfunction

  function automatic int len(input int i);
    return 4 + 7 * ((i != 0) ? HPB : HPA) * td(i);
  endfunction

  // model: each message is a timeline anchored at its GRANT cycle
  int          cyc = 0;
  int          t0[2];
  bit          act[2];
  logic        gr[2];
  logic [11:0] mv[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act = '{1'b0, 1'b0};
      gr  = '{1'b1, 1'b1};
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic r0, r1;
        logic [11:0] a0, a1;
        r0 = (i != 0) ? ifb.req0 : ifa.req0;
        r1 = (i != 0) ? ifb.req1 : ifa.req1;
        a0 = (i != 0) ? ifb.msg0 : ifa.msg0;
        a1 = (i != 0) ? ifb.msg1 : ifa.msg1;
        if (!act[i] || (cyc - t0[i] >= len(i))) begin
          act[i] = 1'b0;
          if (r0 || r1) begin
            gr[i]  = (r0 && r1) ? (RR ? ~gr[i] : 1'b0) : r1;
            mv[i]  = gr[i] ? a1 : a0;
            t0[i]  = cyc + 1;
            act[i] = 1'b1;
          end
        end
      end
      cyc++;
    end
  end

  function automatic out_t expv(input int i);
    out_t e;
    int   o;
    int   s;
    e        = '0;
    e.ld_dec = 4'hF;
    e.grant  = gr[i];
    o        = cyc - t0[i];
    if (act[i] && o < len(i)) begin
      e.busy = 1'b1;
      if (o == 0) begin
        e.ack0 = ~gr[i];
        e.ack1 = gr[i];
      end else if (o <= 3) begin
        e.ld_rd  = 1'b1;
        e.ld_dec = 4'(mv[i] >> (4 * (3 - o)));
      end else begin
        s      = o - 4;
        e.tick = ((s % td(i)) == td(i) - 1);
        e.step = 3'((s / td(i)) % 7);
      end
    end
    return e;
  endfunction

  function automatic out_t obs(input int i);
    out_t o;
    if (i != 0)
      o = {ifb.ack0, ifb.ack1, ifb.ld_rd, ifb.ld_dec,
           ifb.tick, ifb.step, ifb.busy, ifb.grant};
    else
      o = {ifa.ack0, ifa.ack1, ifa.ld_rd, ifa.ld_dec,
           ifa.tick, ifa.step, ifa.busy, ifa.grant};
    return o;
  endfunction

  task automatic cmp_all();
    out_t e;
    out_t o;
    for (int i = 0; i < 2; i++) begin
      e = expv(i);
      o = obs(i);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL cycle inst%0d t=%0t: got %h want %h",
                 i, $time, o, e);
      end
    end
  endtask

  task automatic lit(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic ld3(input int i, input logic [11:0] m);
    out_t o;
    for (int d = 0; d < 3; d++) begin
      nclk();
      o = obs(i);
      lit("load", {o.ld_rd, o.ld_dec}, {1'b1, m[11-4*d -: 4]});
    end
  endtask

  task automatic wait_ack(input int i, output int who);
    out_t o;
    who = 15;
    for (int c = 0; c < 200; c++) begin
      nclk();
      o = obs(i);
      if (o.ack0) begin who = 0; break; end
      if (o.ack1) begin who = 1; break; end
    end
  endtask

  task automatic wait_idle(input int i);
    out_t o;
    for (int c = 0; c < 300; c++) begin
      nclk();
      o = obs(i);
      if (!o.busy) break;
    end
    lit("idle", o.busy, 0);
  endtask

  task automatic measure(input int i, output int sc, output int nt,
                         output int ft, output int nw,
                         output logic [31:0] seq, output logic lt);
    out_t       o;
    logic       pt;
    logic [2:0] ps;
    sc = 0; nt = 0; ft = 0; nw = 0;
    seq = '0; lt = 1'b0; pt = 1'b0; ps = '0;
    for (int c = 0; c < 500; c++) begin
      nclk();
      o = obs(i);
      if (pt) seq = {seq[27:0], 1'b0, o.step};
      if (ps == 3'd6 && o.step == 3'd0) nw++;
      if (!o.busy) break;
      sc++;
      if (o.tick) begin
        nt++;
        if (nt == 1) ft = sc;
      end
      pt = o.tick;
      ps = o.step;
      lt = o.tick;
    end
  endtask

  task automatic rnd_req(input logic r, input logic a,
                         input logic [11:0] m,
                         output logic rn, output logic [11:0] mn);
    rn = r;
    mn = m;
    if (r && a) begin
      rn = ($urandom_range(0, 2) == 0);
      mn = 12'($urandom);
    end else if (!r && $urandom_range(0, 5) == 0) begin
      rn = 1'b1;
      mn = 12'($urandom);
    end
  endtask

  initial begin
    int who;
    int sc, nt, ft, nw;
    int nack;
    logic [31:0] seq;
    logic lt;
    out_t o;

    rst = 1'b0;
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    ifa.msg0 = '0;   ifa.msg1 = '0;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0;
    ifb.msg0 = '0;   ifb.msg1 = '0;
    #1 rst = 1'b1;
    #1;
    lit("rst_pre_a", obs(0), 13'h3C1);
    lit("rst_pre_b", obs(1), 13'h3C1);
    cmp_all();
    repeat (3) nclk();
    lit("rst_held_a", obs(0), 13'h3C1);
    lit("rst_held_b", obs(1), 13'h3C1);
    #2 rst = 1'b0;

    // single message on the TICK_DIV=4 unit
    nclk();
    ifa.req0 = 1'b1;
    ifa.msg0 = 12'h123;
    nclk();
    lit("s_ack", {ifa.ack0, ifa.ack1, ifa.busy, ifa.grant}, 4'b1010);
    ifa.req0 = 1'b0;
    ld3(0, 12'h123);
    measure(0, sc, nt, ft, nw, seq, lt);
    lit("s_show_len", sc, 28);
    lit("s_ticks", nt, 7);
    lit("s_first_tick", ft, 4);
    lit("s_steps", seq, 32'h1234560);
    lit("s_wraps", nw, 1);
    lit("s_last_tick", lt, 1);

    // multi-pass hold on the TICK_DIV=2, HOLD_PASSES=3 unit
    ifb.req0 = 1'b1;
    ifb.msg0 = 12'hABC;
    nclk();
    lit("m_ack", {ifb.ack0, ifb.busy}, 2'b11);
    ifb.req0 = 1'b0;
    ld3(1, 12'hABC);
    measure(1, sc, nt, ft, nw, seq, lt);
    lit("m_show_len", sc, 42);
    lit("m_ticks", nt, 21);
    lit("m_first_tick", ft, 2);
    lit("m_wraps", nw, 3);
    lit("m_last_tick", lt, 1);

    // reset in the second load cycle, then re-grant
    wait_idle(0);
    ifa.req0 = 1'b1;
    ifa.msg0 = 12'h4E2;
    nclk();
    lit("r_ack", {ifa.ack0, ifa.busy}, 2'b11);
    nclk();
    lit("r_ld1", {ifa.ld_rd, ifa.ld_dec}, 5'h14);
    nclk();
    lit("r_ld2", {ifa.ld_rd, ifa.ld_dec}, 5'h1E);
    #2 rst = 1'b1;
    #1;
    lit("r_abort", {ifa.ld_rd, ifa.ld_dec, ifa.busy}, 6'h1E);
    nclk();
    #2 rst = 1'b0;
    nclk();
    lit("r_reack", {ifa.ack0, ifa.busy}, 2'b11);
    ifa.req0 = 1'b0;
    ld3(0, 12'h4E2);

    // request raised during SHOW waits for IDLE
    repeat (5) nclk();
    ifa.req1 = 1'b1;
    ifa.msg1 = 12'h9E7;
    nack = 0;
    for (int c = 0; c < 200; c++) begin
      nclk();
      if (!ifa.busy) break;
      if (ifa.ack1) nack++;
    end
    lit("q_no_ack_busy", nack, 0);
    lit("q_idle_no_ack", {ifa.ack1, ifa.busy}, 2'b00);
    nclk();
    lit("q_ack1", {ifa.ack1, ifa.busy, ifa.grant}, 3'b111);
    ifa.req1 = 1'b0;
    ld3(0, 12'h9E7);
    wait_idle(0);

    // contention from reset state
    #2 rst = 1'b1;
    nclk();
    #2 rst = 1'b0;
    ifa.req0 = 1'b1; ifa.msg0 = 12'hAAA;
    ifa.req1 = 1'b1; ifa.msg1 = 12'h555;
    wait_ack(0, who);
    lit("cont1", who, 0);
    wait_ack(0, who);
    lit("cont2", who, RR ? 1 : 0);
    wait_ack(0, who);
    lit("cont3", who, 0);
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
    wait_idle(0);

    // randomized requesters on both units
    for (int c = 0; c < 3000; c++) begin
      nclk();
      rnd_req(ifa.req0, ifa.ack0, ifa.msg0, ifa.req0, ifa.msg0);
      rnd_req(ifa.req1, ifa.ack1, ifa.msg1, ifa.req1, ifa.msg1);
      rnd_req(ifb.req0, ifb.ack0, ifb.msg0, ifb.req0, ifb.msg0);
      rnd_req(ifb.req1, ifb.ack1, ifb.msg1, ifb.req1, ifb.msg1);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        nclk();
        #2 rst = 1'b0;
      end
    end
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0;
    wait_idle(0);
    wait_idle(1);
    o = obs(0);
    lit("end_dec", o.ld_dec, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
